// File: rtl/mips_ula_muldiv.sv
// Iterative multiply/divide unit beside the MIPS ALU. It owns HI/LO and
// retires one shift/add or shift/subtract step per clock.
module mips_ula_muldiv #(
    parameter int WSIZE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WSIZE-1:0] A,
    input  logic [WSIZE-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WSIZE-1:0] R,
    output logic             Z,
    output logic             O,
    output logic [WSIZE-1:0] HI,
    output logic [WSIZE-1:0] LO
);
    localparam int CW = $clog2(WSIZE);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WSIZE:0]   r_hi;        // product upper half + carry, or partial remainder
    logic [WSIZE-1:0] r_lo;        // multiplier, or dividend shifting into quotient
    logic [WSIZE-1:0] r_op;        // multiplicand or divisor magnitude
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_err;

    logic             w_signed;
    logic             w_iter;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WSIZE-1:0] w_a_mag;
    logic [WSIZE-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [WSIZE:0]   w_mul_sum;
    logic [WSIZE:0]   w_div_shift;
    logic [WSIZE+1:0] w_div_trial;
    logic [2*WSIZE-1:0] w_prod;
    logic [2*WSIZE-1:0] w_prod_fix;
    logic [WSIZE-1:0] w_quot;
    logic [WSIZE-1:0] w_rem;
    logic [WSIZE-1:0] w_move_val;

    assign w_signed   = ~opcode[0];
    assign w_iter     = (opcode[3:2] == 2'b00);
    assign w_a_neg    = w_signed & A[WSIZE-1];
    assign w_b_neg    = w_signed & B[WSIZE-1];
    assign w_a_mag    = w_a_neg ? (~A + 1'b1) : A;
    assign w_b_mag    = w_b_neg ? (~B + 1'b1) : B;
    assign w_div_zero = (B == '0);
    assign w_div_ovf  = w_signed && (A == {1'b1, {(WSIZE-1){1'b0}}}) && (B == '1);

    assign w_mul_sum   = r_hi + (r_lo[0] ? {1'b0, r_op} : '0);
    assign w_div_shift = {r_hi[WSIZE-1:0], r_lo[WSIZE-1]};
    assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_op};

    assign w_prod     = {r_hi[WSIZE-1:0], r_lo};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quot     = r_neg_q ? (~r_lo + 1'b1) : r_lo;
    assign w_rem      = r_neg_r ? (~r_hi[WSIZE-1:0] + 1'b1) : r_hi[WSIZE-1:0];

    always_comb begin
        w_move_val = A;
        case (opcode[1:0])
            2'b00:   w_move_val = HI;
            2'b01:   w_move_val = LO;
            default: w_move_val = A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_err    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            R        <= '0;
            Z        <= 1'b0;
            O        <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (start && w_iter) begin
                        r_state  <= S_CALC;
                        busy     <= 1'b1;
                        r_cnt    <= CW'(WSIZE - 1);
                        r_is_div <= opcode[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_err    <= opcode[1] & (w_div_zero | w_div_ovf);
                        r_hi     <= '0;
                        r_lo     <= opcode[1] ? w_a_mag : w_b_mag;
                        r_op     <= opcode[1] ? w_b_mag : w_a_mag;
                    end else if (start) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        O       <= 1'b0;
                        if (opcode[3]) begin
                            R <= '0;
                            Z <= 1'b1;
                        end else begin
                            R <= w_move_val;
                            Z <= (w_move_val == '0);
                            if (opcode[1:0] == 2'b10) HI <= A;
                            if (opcode[1:0] == 2'b11) LO <= A;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        // Restoring step: keep the subtraction only when it did not borrow.
                        if (!w_div_trial[WSIZE+1]) begin
                            r_hi <= w_div_trial[WSIZE:0];
                            r_lo <= {r_lo[WSIZE-2:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shift;
                            r_lo <= {r_lo[WSIZE-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {1'b0, w_mul_sum[WSIZE:1]};
                        r_lo <= {w_mul_sum[0], r_lo[WSIZE-1:1]};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (!r_is_div) begin
                        HI <= w_prod_fix[2*WSIZE-1:WSIZE];
                        LO <= w_prod_fix[WSIZE-1:0];
                        R  <= w_prod_fix[WSIZE-1:0];
                        Z  <= (w_prod_fix == '0);
                        O  <= 1'b0;
                    end else if (r_err) begin
                        R <= '0;
                        Z <= 1'b1;
                        O <= 1'b1;
                    end else begin
                        LO <= w_quot;
                        HI <= w_rem;
                        R  <= w_quot;
                        Z  <= (w_quot == '0);
                        O  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_ula_muldiv.sv
// Directed-vector bench for mips_ula_muldiv: each task drives one scenario
// and compares against hand-computed results.
module tb_mips_ula_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   opcode = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Z, O;
    logic [W-1:0] R, HI, LO;

    int n_cmp = 0;
    int n_fail = 0;

    mips_ula_muldiv #(.WSIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .A(A), .B(B), .busy(busy), .done(done), .R(R), .Z(Z), .O(O),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Issue one op now, then wait (bounded) for done; lat is the cycle count
    // after the accepting edge, -1 if done never arrived.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
        opcode = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        $display("op=%b A=%h B=%h lat=%0d R=%h Z=%b O=%b HI=%h LO=%h",
                 op, a, b, lat, R, Z, O, HI, LO);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done); end
        n_cmp++; if (R !== '0 || Z !== 1'b0 || O !== 1'b0) begin n_fail++;
            $display("FAIL reset_rzo: R=%h Z=%b O=%b required 0 0 0", R, Z, O); end
        n_cmp++; if (HI !== '0 || LO !== '0) begin n_fail++;
            $display("FAIL reset_hilo: HI=%h LO=%h required 0 0", HI, LO); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        int lat;
        run_op(4'b0000, 32'hFFFFFFFD, 32'd5, lat);
        n_cmp++; if (lat !== 34) begin n_fail++;
            $display("FAIL mult_lat: got %0d required 34", lat); end
        n_cmp++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1) begin n_fail++;
            $display("FAIL mult_hilo: HI=%h LO=%h required FFFFFFFF FFFFFFF1", HI, LO); end
        n_cmp++; if (R !== 32'hFFFFFFF1 || Z !== 1'b0 || O !== 1'b0) begin n_fail++;
            $display("FAIL mult_rzo: R=%h Z=%b O=%b required FFFFFFF1 0 0", R, Z, O); end
        // MFLO back-to-back in the done cycle sees the fresh LO
        run_op(4'b0101, 32'd0, 32'd0, lat);
        n_cmp++; if (lat !== 1 || R !== 32'hFFFFFFF1) begin n_fail++;
            $display("FAIL mflo_b2b: lat=%0d R=%h required 1 FFFFFFF1", lat, R); end
    endtask

    task automatic test_multu();
        int lat;
        run_op(4'b0001, 32'hFFFFFFFD, 32'd5, lat);
        n_cmp++; if (lat !== 34) begin n_fail++;
            $display("FAIL multu_lat: got %0d required 34", lat); end
        n_cmp++; if (HI !== 32'h00000004 || LO !== 32'hFFFFFFF1 || R !== 32'hFFFFFFF1) begin n_fail++;
            $display("FAIL multu_res: HI=%h LO=%h R=%h required 00000004 FFFFFFF1 FFFFFFF1", HI, LO, R); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL done_pulse: done=%b required 0", done); end
    endtask

    task automatic test_div();
        int lat;
        run_op(4'b0011, 32'd100, 32'd7, lat);
        n_cmp++; if (lat !== 34) begin n_fail++;
            $display("FAIL divu_lat: got %0d required 34", lat); end
        n_cmp++; if (LO !== 32'd14 || HI !== 32'd2 || R !== 32'd14 || Z !== 1'b0 || O !== 1'b0) begin n_fail++;
            $display("FAIL divu_res: LO=%h HI=%h R=%h Z=%b O=%b required e 2 e 0 0", LO, HI, R, Z, O); end
        run_op(4'b0010, 32'hFFFFFFF9, 32'd2, lat);
        n_cmp++; if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF || R !== 32'hFFFFFFFD) begin n_fail++;
            $display("FAIL div_signed: LO=%h HI=%h R=%h required FFFFFFFD FFFFFFFF FFFFFFFD", LO, HI, R); end
        run_op(4'b0011, 32'd3, 32'd9, lat);
        n_cmp++; if (LO !== 32'd0 || HI !== 32'd3 || Z !== 1'b1) begin n_fail++;
            $display("FAIL divu_zero_q: LO=%h HI=%h Z=%b required 0 3 1", LO, HI, Z); end
    endtask

    task automatic test_div_errors();
        int lat;
        run_op(4'b0110, 32'h12345678, 32'd0, lat);
        run_op(4'b0111, 32'h12345678, 32'd0, lat);
        run_op(4'b0010, 32'd55, 32'd0, lat);
        n_cmp++; if (lat !== 34) begin n_fail++;
            $display("FAIL divz_lat: got %0d required 34", lat); end
        n_cmp++; if (O !== 1'b1 || Z !== 1'b1 || R !== '0) begin n_fail++;
            $display("FAIL divz_rzo: R=%h Z=%b O=%b required 0 1 1", R, Z, O); end
        n_cmp++; if (HI !== 32'h12345678 || LO !== 32'h12345678) begin n_fail++;
            $display("FAIL divz_hilo: HI=%h LO=%h required 12345678 12345678", HI, LO); end
        run_op(4'b0011, 32'd55, 32'd0, lat);
        n_cmp++; if (O !== 1'b1 || Z !== 1'b1 || R !== '0 || LO !== 32'h12345678) begin n_fail++;
            $display("FAIL divuz: R=%h Z=%b O=%b LO=%h required 0 1 1 12345678", R, Z, O, LO); end
        run_op(4'b0010, 32'h80000000, 32'hFFFFFFFF, lat);
        n_cmp++; if (O !== 1'b1 || Z !== 1'b1 || R !== '0 || HI !== 32'h12345678) begin n_fail++;
            $display("FAIL div_ovf: R=%h Z=%b O=%b HI=%h required 0 1 1 12345678", R, Z, O, HI); end
    endtask

    task automatic test_moves();
        int lat;
        run_op(4'b0110, 32'hDEADBEEF, 32'd0, lat);
        n_cmp++; if (lat !== 1 || HI !== 32'hDEADBEEF || R !== 32'hDEADBEEF || busy !== 1'b0) begin n_fail++;
            $display("FAIL mthi: lat=%0d HI=%h R=%h busy=%b required 1 DEADBEEF DEADBEEF 0", lat, HI, R, busy); end
        run_op(4'b0100, 32'd0, 32'd0, lat);
        n_cmp++; if (lat !== 1 || R !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL mfhi_b2b: lat=%0d R=%h required 1 DEADBEEF", lat, R); end
        run_op(4'b1010, 32'h11111111, 32'd0, lat);
        n_cmp++; if (lat !== 1 || R !== '0 || Z !== 1'b1 || O !== 1'b0) begin n_fail++;
            $display("FAIL unknown_op: lat=%0d R=%h Z=%b O=%b required 1 0 1 0", lat, R, Z, O); end
        n_cmp++; if (HI !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL unknown_hi: HI=%h required DEADBEEF", HI); end
    endtask

    task automatic test_ignore_start();
        int first_done = -1;
        int n_done = 0;
        logic [W-1:0] r_seen = '0;
        opcode = 4'b0000; A = 32'hFFFFFFFD; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++;
                    $display("FAIL busy_rise: busy=%b required 1", busy); end
            end
            if (done) begin
                n_done++;
                if (first_done < 0) begin first_done = c; r_seen = R; end
            end
            if (c == 5) begin opcode = 4'b0011; A = 32'd100; B = 32'd7; start = 1'b1; end
            if (c == 6) start = 1'b0;
            @(posedge clk); #1;
        end
        $display("ignore: first_done=%0d n_done=%0d R=%h", first_done, n_done, r_seen);
        n_cmp++; if (first_done !== 34 || n_done !== 1) begin n_fail++;
            $display("FAIL ignore_done: first=%0d count=%0d required 34 1", first_done, n_done); end
        n_cmp++; if (r_seen !== 32'hFFFFFFF1 || HI !== 32'hFFFFFFFF) begin n_fail++;
            $display("FAIL ignore_res: R=%h HI=%h required FFFFFFF1 FFFFFFFF", r_seen, HI); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n_done = 0;
        opcode = 4'b0010; A = 32'hFFFFFFF9; B = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset_mid: busy=%b done=%b R=%h HI=%h LO=%h", busy, done, R, HI, LO);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || R !== '0 || Z !== 1'b0 || O !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_out: busy=%b done=%b R=%h Z=%b O=%b required 0 0 0 0 0", busy, done, R, Z, O); end
        n_cmp++; if (HI !== '0 || LO !== '0) begin n_fail++;
            $display("FAIL rstmid_hilo: HI=%h LO=%h required 0 0", HI, LO); end
        for (int c = 0; c < 40; c++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        n_cmp++; if (n_done !== 0) begin n_fail++;
            $display("FAIL rstmid_nodone: count=%0d required 0", n_done); end
        run_op(4'b0011, 32'd100, 32'd7, lat);
        n_cmp++; if (lat !== 34 || LO !== 32'd14 || HI !== 32'd2) begin n_fail++;
            $display("FAIL rstmid_after: lat=%0d LO=%h HI=%h required 34 e 2", lat, LO, HI); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        @(negedge clk);
        test_div();
        test_div_errors();
        test_moves();
        @(negedge clk);
        test_ignore_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
